router_fifo: RTL and testbench

Output-channel buffer of the 1x3 router. One instance sits directly downstream of the synchroniser on each of the three output ports. It stores packet bytes written under `write_enb[n]`, and reports `full` and `empty`, which feed the synchroniser's `full_n`/`empty_n` inputs and `vld_out_n`. It releases bytes to the destination under `read_enb_n` and tracks packet boundaries so `data_out` returns to idle after each packet's parity byte. A `soft_reset` from the synchroniser's read-timeout logic flushes a stalled channel.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_fifo.sv | 98 +++++++++
 tb/tb_router_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, buffer depth,
// header field positions and the packet counter width.
package router_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int FIFO_DEPTH   = 16;

    // Header byte layout: destination address in the low bits, payload length above.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam int PKT_CNT_W    = 7;

    // Bytes still to come after a header: the payload plus the trailing parity byte.
    function automatic logic [PKT_CNT_W-1:0] pktBytesAfterHeader(
        input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] lenField
    );
        return {1'b0, lenField} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Output-channel buffer of the 1x3 router. Stores packet bytes tagged with a
// header marker, reports full/empty from the pointers, and tracks packet
// boundaries so data_out drops back to zero once a packet's parity byte is out.
module router_fifo #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int DEPTH      = router_pkg::FIFO_DEPTH
) (
    input  logic                  router_clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // Each entry carries the byte plus the header marker in its top bit.
    logic [DATA_WIDTH:0]     mem_q [DEPTH];

    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

    logic                    flush;
    logic                    doWrite;
    logic                    doRead;
    logic [DATA_WIDTH:0]     popEntry;

    // Flags come straight from the pointers; the extra MSB separates full from empty.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // A flush cycle swallows any write or read; otherwise honour the flags seen before the edge.
    always_comb begin
        flush    = reset || soft_reset;
        doWrite  = write_enb && !full && !flush;
        doRead   = read_enb && !empty && !flush;
        popEntry = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers, packet counter and the output byte.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (doWrite) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (doRead) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = popEntry[DATA_WIDTH-1:0];
            if (popEntry[DATA_WIDTH]) begin
                pkt_cnt_d = pktBytesAfterHeader(popEntry[HDR_LEN_MSB:HDR_LEN_LSB]);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - 1'b1;
            end
        end else if (pkt_cnt_q == '0) begin
            data_out_d = '0;
        end
    end

    // Control state register; hard reset and timeout flush both clear it.
    always_ff @(posedge router_clock) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array is never cleared; stale entries become unreachable after a flush.
    always_ff @(posedge router_clock) begin
        if (doWrite) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, one packet, full,
// full with simultaneous access, mid-packet flush, empty reads and pointer wrap.
module tb_router_fifo;

    logic       router_clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int vectorCount = 0;
    int missCount   = 0;

    router_fifo dut (
        .router_clock (router_clock),
        .reset        (reset),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty)
    );

    // Free-running 10-unit clock.
    initial begin
        router_clock = 1'b0;
        forever #5 router_clock = ~router_clock;
    end

    // Drive one cycle of inputs, then return 1 unit after the capturing edge.
    task automatic applyStimulus(input logic rst, input logic srst, input logic we,
                                 input logic lfd, input logic [7:0] din, input logic re);
        reset      = rst;
        soft_reset = srst;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        @(posedge router_clock);
        #1;
        reset      = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        read_enb   = 1'b0;
    endtask

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeByte(input logic lfd, input logic [7:0] din);
        applyStimulus(1'b0, 1'b0, 1'b1, lfd, din, 1'b0);
    endtask

    task automatic readByte();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic hardReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [7:0] pktBytes [5];
        logic [7:0] wrapByte;

        reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00; read_enb = 1'b0;
        hardReset();

        // Reset after traffic: header 0x0D popped leaves 4 bytes pending, then reset clears all.
        writeByte(1'b1, 8'h0D);
        for (int i = 0; i < 3; i++) writeByte(1'b0, 8'($urandom_range(0, 255)));
        readByte();
        checkOutput("pre_reset_hdr", 32'(data_out), 32'h0D);
        checkOutput("pre_reset_cnt", 32'(dut.pkt_cnt_q), 32'd4);
        hardReset();
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_cnt", 32'(dut.pkt_cnt_q), 32'd0);

        // One packet: header 0x0D (length 3), payload A1..A3, parity 5F.
        pktBytes = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
        for (int i = 0; i < 5; i++) writeByte(i == 0, pktBytes[i]);
        checkOutput("pkt_not_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            readByte();
            checkOutput($sformatf("pkt_byte%0d", i), 32'(data_out), 32'(pktBytes[i]));
        end
        checkOutput("pkt_drained", 32'(empty), 32'd1);
        idleCycle();
        checkOutput("pkt_idle_zero", 32'(data_out), 32'd0);

        // Full: 17 writes, the last one dropped.
        hardReset();
        for (int i = 0; i < 17; i++) begin
            writeByte(1'b0, 8'(i));
            if (i == 14) checkOutput("full_at15", 32'(full), 32'd0);
            if (i == 15) checkOutput("full_at16", 32'(full), 32'd1);
        end
        checkOutput("full_after17", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            readByte();
            checkOutput($sformatf("full_rd%0d", i), 32'(data_out), 32'(i));
        end
        checkOutput("full_drained", 32'(empty), 32'd1);
        readByte();
        checkOutput("full_no17th", 32'(data_out), 32'd0);

        // Full with simultaneous write and read: oldest out, 0x77 dropped.
        hardReset();
        for (int i = 0; i < 16; i++) writeByte(1'b0, 8'(8'h20 + i));
        checkOutput("simul_full", 32'(full), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
        checkOutput("simul_data", 32'(data_out), 32'h20);
        checkOutput("simul_notfull", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            readByte();
            checkOutput($sformatf("simul_rd%0d", i), 32'(data_out), 32'(8'h20 + i));
        end
        checkOutput("simul_occ15", 32'(empty), 32'd1);

        // Flush mid-packet after header and two payload bytes were read.
        hardReset();
        for (int i = 0; i < 5; i++) writeByte(i == 0, pktBytes[i]);
        for (int i = 0; i < 3; i++) readByte();
        checkOutput("flush_pre_data", 32'(data_out), 32'hA2);
        idleCycle();
        checkOutput("flush_hold", 32'(data_out), 32'hA2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_data", 32'(data_out), 32'd0);
        writeByte(1'b1, 8'h05);
        writeByte(1'b0, 8'h3C);
        writeByte(1'b0, 8'h39);
        readByte();
        checkOutput("flush_new_hdr", 32'(data_out), 32'h05);
        readByte();
        checkOutput("flush_new_pay", 32'(data_out), 32'h3C);
        readByte();
        checkOutput("flush_new_par", 32'(data_out), 32'h39);
        idleCycle();
        checkOutput("flush_new_idle", 32'(data_out), 32'd0);

        // Reads while empty move nothing; simultaneous write+read while empty keeps the write.
        hardReset();
        for (int i = 0; i < 3; i++) begin
            readByte();
            checkOutput($sformatf("emptyrd_data%0d", i), 32'(data_out), 32'd0);
            checkOutput($sformatf("emptyrd_empty%0d", i), 32'(empty), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b1);
        checkOutput("wr_rd_empty_e", 32'(empty), 32'd0);
        checkOutput("wr_rd_empty_d", 32'(data_out), 32'd0);
        readByte();
        checkOutput("wr_rd_empty_rd", 32'(data_out), 32'h99);
        checkOutput("wr_rd_empty_after", 32'(empty), 32'd1);

        // Stream 40 single-byte write/read pairs across two pointer wraps.
        for (int i = 0; i < 40; i++) begin
            wrapByte = 8'(i * 7 + 3);
            writeByte(1'b0, wrapByte);
            readByte();
            checkOutput($sformatf("wrap%0d", i), 32'(data_out), 32'(wrapByte));
        end
        checkOutput("wrap_empty", 32'(empty), 32'd1);
        checkOutput("wrap_full", 32'(full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
